// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with 16x oversampling that decodes single-byte commands into one-cycle pulses.
// Define CMD_LOWERCASE_EN to also accept lowercase command letters.
module uart_cmd_rx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       o_clear,
   output logic       o_runstop,
   output logic       o_up,
   output logic       o_down,
   output logic       o_mode,
   output logic [2:0] fsm_state
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state, state_n;
   logic          rx_s1, rx_s;
   logic [CW-1:0] baud_cnt;
   logic          tick;
   logic [3:0]    tick_cnt, tick_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shift, shift_n;
   logic [7:0]    data_n;
   logic          done_n, ferr_n;

   assign fsm_state = state;

   // Line is idle-high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_s1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s  <= rx_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         baud_cnt <= '0;
      else if (baud_cnt == DIV_LAST)
         baud_cnt <= '0;
      else
         baud_cnt <= baud_cnt + 1'b1;
   end

   assign tick = (baud_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         tick_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         rx_data   <= 8'h00;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_cnt_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         rx_data   <= data_n;
         rx_done   <= done_n;
         frame_err <= ferr_n;
      end
   end

   // START checks mid start bit (8 ticks); DATA/STOP then sample every 16 ticks at mid-bit.
   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift;
      data_n     = rx_data;
      done_n     = 1'b0;
      ferr_n     = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n    = START;
                  tick_cnt_n = 4'd0;
               end
            end
            START: begin
               if (tick_cnt == 4'd7) begin
                  tick_cnt_n = 4'd0;
                  bit_cnt_n  = 3'd0;
                  state_n    = rx_s ? IDLE : DATA;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            DATA: begin
               if (tick_cnt == 4'd15) begin
                  tick_cnt_n = 4'd0;
                  shift_n    = {rx_s, shift[7:1]};
                  if (bit_cnt == 3'd7)
                     state_n = STOP;
                  else
                     bit_cnt_n = bit_cnt + 3'd1;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            STOP: begin
               if (tick_cnt == 4'd15) begin
                  tick_cnt_n = 4'd0;
                  if (rx_s) begin
                     data_n  = shift;
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = WAIT_HIGH;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            WAIT_HIGH: begin
               // A held-low line (break) must not retrigger framing errors.
               if (rx_s)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         o_clear   <= 1'b0;
         o_runstop <= 1'b0;
         o_up      <= 1'b0;
         o_down    <= 1'b0;
         o_mode    <= 1'b0;
      end else begin
         o_clear   <= 1'b0;
         o_runstop <= 1'b0;
         o_up      <= 1'b0;
         o_down    <= 1'b0;
         if (rx_done) begin
            case (rx_data)
`ifdef CMD_LOWERCASE_EN
               8'h43, 8'h63: o_clear   <= 1'b1;
               8'h52, 8'h72: o_runstop <= 1'b1;
               8'h55, 8'h75: o_up      <= 1'b1;
               8'h44, 8'h64: o_down    <= 1'b1;
               8'h4D, 8'h6D: o_mode    <= ~o_mode;
`else
               8'h43: o_clear   <= 1'b1;
               8'h52: o_runstop <= 1'b1;
               8'h55: o_up      <= 1'b1;
               8'h44: o_down    <= 1'b1;
               8'h4D: o_mode    <= ~o_mode;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a 4-clock oversample tick (64-clock bit period).
module tb_uart_cmd_rx;

   localparam int BIT = 64;
`ifdef CMD_LOWERCASE_EN
   localparam int LC = 1;
`else
   localparam int LC = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done, frame_err;
   logic       o_clear, o_runstop, o_up, o_down, o_mode;
   logic [2:0] fsm_state;

   uart_cmd_rx #(.CLK_FREQ(1_000_000), .BAUD(15625)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err),
      .o_clear(o_clear), .o_runstop(o_runstop), .o_up(o_up), .o_down(o_down),
      .o_mode(o_mode), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_done = 0, cnt_ferr = 0, cnt_clear = 0, cnt_run = 0;
   int cnt_up = 0, cnt_down = 0, cnt_mode = 0, lag_err = 0;
   logic prev_done = 1'b0, prev_cmd = 1'b0, prev_mode = 1'b0;

   // Event counters plus timing rules: pulses only the cycle after rx_done, one cycle wide, one at a time.
   always @(negedge clk) begin
      int ncmd;
      ncmd = int'(o_clear) + int'(o_runstop) + int'(o_up) + int'(o_down);
      if (rx_done)   cnt_done++;
      if (frame_err) cnt_ferr++;
      if (o_clear)   cnt_clear++;
      if (o_runstop) cnt_run++;
      if (o_up)      cnt_up++;
      if (o_down)    cnt_down++;
      if (o_mode != prev_mode && rst) begin
         cnt_mode++;
         if (!prev_done) lag_err++;
      end
      if (ncmd > 0 && !prev_done) lag_err++;
      if (ncmd > 0 && prev_cmd)   lag_err++;
      if (ncmd > 1)               lag_err++;
      prev_done = rx_done;
      prev_cmd  = (ncmd > 0);
      prev_mode = o_mode;
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      clks(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         clks(BIT);
      end
      rx = stop_bit;
      clks(BIT);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      rx  = 1'b1;
      clks(5);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_done", 32'(rx_done), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_cmds", {o_clear, o_runstop, o_up, o_down}, 0);
      check("rst_mode", 32'(o_mode), 0);
      check("rst_state", 32'(fsm_state), 0);
      rst = 1'b1;
      clks(BIT);

      send_byte(8'h52, 1'b1);
      check("R_done", cnt_done, 1);
      check("R_data", 32'(rx_data), 32'h52);
      check("R_runstop", cnt_run, 1);
      check("R_others", cnt_clear + cnt_up + cnt_down + cnt_mode, 0);

      send_byte(8'h4D, 1'b1);
      check("M1_mode", 32'(o_mode), 1);
      send_byte(8'h4D, 1'b1);
      check("M2_mode", 32'(o_mode), 0);
      check("M_done", cnt_done, 3);
      check("M_toggles", cnt_mode, 2);
      check("M_no_pulse", cnt_clear + cnt_run + cnt_up + cnt_down, 1);

      send_byte(8'h75, 1'b1);
      check("u_done", cnt_done, 4);
      check("u_data", 32'(rx_data), 32'h75);
      check("u_up", cnt_up, LC);

      send_byte(8'h63, 1'b1);
      check("c_data", 32'(rx_data), 32'h63);
      check("c_clear", cnt_clear, LC);

      send_byte(8'h43, 1'b0);
      clks(30 * BIT);
      rx = 1'b1;
      clks(2 * BIT);
      check("ferr_count", cnt_ferr, 1);
      check("ferr_no_done", cnt_done, 5);
      check("ferr_no_clear", cnt_clear, LC);
      check("ferr_data", 32'(rx_data), 32'h63);
      check("ferr_state", 32'(fsm_state), 0);

      send_byte(8'h44, 1'b1);
      check("D_down", cnt_down, 1);
      check("D_data", 32'(rx_data), 32'h44);

      rx = 1'b0;
      clks(18);
      rx = 1'b1;
      clks(2 * BIT);
      check("glitch_done", cnt_done, 6);
      check("glitch_ferr", cnt_ferr, 1);
      check("glitch_state", 32'(fsm_state), 0);

      send_byte(8'h43, 1'b1);
      send_byte(8'h52, 1'b1);
      clks(BIT);
      check("b2b_done", cnt_done, 8);
      check("b2b_clear", cnt_clear, LC + 1);
      check("b2b_run", cnt_run, 2);
      check("b2b_data", 32'(rx_data), 32'h52);

      send_byte(8'h4D, 1'b1);
      check("M3_mode", 32'(o_mode), 1);

      fork
         send_byte(8'h55, 1'b1);
         begin
            clks(3 * BIT);
            rst = 1'b0;
            clks(2);
            check("midrst_state", 32'(fsm_state), 0);
            clks(6 * BIT + BIT / 4 - 2);
            rst = 1'b1;
         end
      join
      clks(BIT);
      check("midrst_data", 32'(rx_data), 32'h00);
      check("midrst_mode", 32'(o_mode), 0);
      check("midrst_done", cnt_done, 9);
      check("midrst_up", cnt_up, LC);

      send_byte(8'h44, 1'b1);
      clks(BIT);
      check("post_down", cnt_down, 2);
      check("post_data", 32'(rx_data), 32'h44);
      check("post_up", cnt_up, LC);
      check("post_ferr", cnt_ferr, 1);
      check("pulse_timing", lag_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
